// File: rtl/apb_debug_requester_pkg.sv
// Shared constants for the debug APB requester: FSM state encoding and default timeout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package apb_debug_requester_pkg;

    // FSM state encoding, kept as plain 2-bit constants for legacy tool flows
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Default number of ACCESS cycles to wait for PREADY before aborting
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/apb_debug_requester.sv
// APB requester for the debugger's narrow APB segment: one host command -> one APB transfer -> one response.
// Latency: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3 + completer wait cycles (timeout aborts after TIMEOUT ACCESS cycles).
// Backpressure: response held until rsp_ready; cmd_ready is low while a transfer or an untaken response is outstanding.
//
// Ports:
//   PCLK, PRESET                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready                host command handshake (cmd_addr, cmd_write, cmd_wdata)
//   rsp_valid/rsp_ready                response handshake (rsp_rdata, rsp_error)
//   busy                               FSM not idle
//   PSEL, PENABLE, PADDR, PWRITE,
//   PWDATA, PRDATA, PREADY             APB requester interface
module apb_debug_requester
    import apb_debug_requester_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,

    output logic              busy,

    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic              pwrite_q,    pwrite_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic              accept;

    // A new command may enter from IDLE, or from RESP in the same cycle the
    // host takes the response, which gives the 3-cycle back-to-back cadence.
    assign cmd_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready);
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            ST_IDLE: begin
                // acceptance handled below
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY wins over the timeout in the final wait cycle
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_error_d = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Latch the command and open the SETUP phase; overrides the IDLE
        // return from RESP when a command arrives in the same cycle.
        if (accept) begin
            paddr_d   = cmd_addr;
            pwrite_d  = cmd_write;
            pwdata_d  = cmd_write ? cmd_wdata : '0;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_apb_debug_requester.sv
// Self-checking bench for apb_debug_requester with a behavioural APB completer.
// Latency: n/a.
// Backpressure: bench drives rsp_ready explicitly per scenario.
module tb_apb_debug_requester;

    localparam int TO = 64;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [4:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_error;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       PSEL, PENABLE, PWRITE, PREADY;
    logic [4:0] PADDR;
    logic [7:0] PWDATA, PRDATA;

    int n_checks = 0;
    int n_pass   = 0;

    // Completer model: register file plus a per-transfer wait count (-1 = never ready)
    logic [7:0] mem [32];
    int comp_wait = 0;
    int acc_k     = 0;

    apb_debug_requester #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Completer responds after comp_wait ACCESS cycles; PRDATA is junk when not ready
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY = (comp_wait >= 0) && (acc_k == comp_wait);
            PRDATA = PREADY ? mem[PADDR] : 8'($urandom);
            acc_k++;
        end else begin
            PREADY = 1'b0;
            PRDATA = 8'($urandom);
            acc_k  = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One complete command/response exchange, checked against the completer model.
    task automatic run_txn(input logic [4:0] a, input logic w, input logic [7:0] wd,
                           input int waits, input int hold);
        bit ok, seen;
        int exp_lat, exp_acc, lat, acc;
        logic [7:0] exp_rd, exp_pwd;
        logic [8:0] held;
        ok      = (waits >= 0) && (waits < TO);
        exp_lat = ok ? waits + 3 : TO + 2;
        exp_acc = ok ? waits + 1 : TO;
        exp_rd  = (ok && !w) ? mem[a] : 8'h00;
        exp_pwd = w ? wd : 8'h00;

        @(negedge PCLK);
        comp_wait = waits;
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = wd; rsp_ready = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        else n_pass++;

        lat = 0; acc = 0; seen = 0;
        while (!seen && lat < TO + 10) begin
            @(negedge PCLK);
            lat++;
            cmd_valid = 1'b0; cmd_addr = 5'($urandom); cmd_wdata = 8'($urandom); cmd_write = 1'($urandom);
            if (lat == 1) begin
                n_checks++;
                if ({PSEL, PENABLE} !== 2'b10) $display("FAIL setup_phase: got %b want 10", {PSEL, PENABLE});
                else n_pass++;
            end
            if (PSEL && PENABLE) acc++;
            if (PSEL) begin
                n_checks++;
                if ({PADDR, PWRITE, PWDATA} !== {a, w, exp_pwd})
                    $display("FAIL apb_stable: got addr %h wr %b wdata %h want addr %h wr %b wdata %h",
                             PADDR, PWRITE, PWDATA, a, w, exp_pwd);
                else n_pass++;
            end
            if (rsp_valid) seen = 1;
        end

        n_checks++;
        if (!seen || lat != exp_lat) $display("FAIL rsp_latency: got %0d (seen=%0d) want %0d", lat, seen, exp_lat);
        else n_pass++;
        n_checks++;
        if (acc != exp_acc) $display("FAIL access_cycles: got %0d want %0d", acc, exp_acc);
        else n_pass++;
        n_checks++;
        if ({rsp_rdata, rsp_error} !== {exp_rd, !ok})
            $display("FAIL rsp_data: got rdata %h err %b want rdata %h err %b", rsp_rdata, rsp_error, exp_rd, !ok);
        else n_pass++;
        n_checks++;
        if ({PSEL, PENABLE} !== 2'b00) $display("FAIL apb_idle_in_resp: got %b want 00", {PSEL, PENABLE});
        else n_pass++;

        held = {rsp_rdata, rsp_error};
        for (int i = 0; i < hold; i++) begin
            @(negedge PCLK);
            n_checks++;
            if ({rsp_valid, rsp_rdata, rsp_error, cmd_ready, PSEL} !== {1'b1, held, 1'b0, 1'b0})
                $display("FAIL bp_hold: got valid %b data %h err %b cmd_ready %b psel %b want 1 %h %b 0 0",
                         rsp_valid, rsp_rdata, rsp_error, cmd_ready, PSEL, held[8:1], held[0]);
            else n_pass++;
        end

        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) $display("FAIL rsp_release: got valid %b busy %b want 0 0", rsp_valid, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata, rsp_error, busy} !== '0)
            $display("FAIL reset_state: got psel %b pen %b addr %h wr %b wdata %h rv %b rd %h err %b busy %b want all 0",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata, rsp_error, busy);
        else n_pass++;
        PRESET = 1'b0;
        @(negedge PCLK);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_read_basic();
        mem[9] = 8'hA5;
        run_txn(5'h09, 1'b0, 8'h00, 0, 0);
    endtask

    task automatic test_write_waits();
        run_txn(5'h02, 1'b1, 8'h3C, 3, 0);
    endtask

    task automatic test_timeout();
        run_txn(5'h1F, 1'b0, 8'h00, -1, 0);       // completer never ready
        run_txn(5'h1E, 1'b0, 8'h00, TO - 1, 0);   // ready in the abort cycle still succeeds
        run_txn(5'h04, 1'b1, 8'h77, -1, 0);       // aborted write
        run_txn(5'h05, 1'b0, 8'h00, 0, 0);        // next command proceeds normally
    endtask

    task automatic test_backpressure();
        run_txn(5'h0C, 1'b0, 8'h00, 1, 10);
        run_txn(5'h0D, 1'b1, 8'h5A, 0, 10);
    endtask

    task automatic test_back_to_back();
        logic [4:0] addrs [3];
        logic [7:0] exp_q [$];
        int rises [$];
        int issued, got, cyc, last_fall;
        logic prev_pen;
        logic [7:0] exp_d;
        addrs[0] = 5'h11; addrs[1] = 5'h12; addrs[2] = 5'h13;
        for (int i = 0; i < 3; i++) mem[addrs[i]] = 8'($urandom);
        comp_wait = 0;
        issued = 0; got = 0; cyc = 0; last_fall = -1; prev_pen = 1'b0;
        @(negedge PCLK);
        rsp_ready = 1'b1; cmd_write = 1'b0;
        while (got < 3 && cyc < 40) begin
            if (rsp_valid) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_checks++;
                if ({rsp_rdata, rsp_error} !== {exp_d, 1'b0})
                    $display("FAIL b2b_rsp%0d: got rdata %h err %b want rdata %h err 0", got, rsp_rdata, rsp_error, exp_d);
                else n_pass++;
                got++;
            end
            if (PENABLE && !prev_pen) begin
                rises.push_back(cyc);
                if (last_fall >= 0) begin
                    // RESP and SETUP both sit between consecutive ACCESS phases
                    n_checks++;
                    if (cyc - last_fall != 2) $display("FAIL b2b_penable_gap: got %0d want 2", cyc - last_fall);
                    else n_pass++;
                end
            end
            if (!PENABLE && prev_pen) last_fall = cyc;
            prev_pen = PENABLE;
            cmd_valid = (issued < 3);
            if (issued < 3) begin
                cmd_addr = addrs[issued];
                if (cmd_ready) begin
                    exp_q.push_back(mem[addrs[issued]]);
                    issued++;
                end
            end
            @(negedge PCLK);
            cyc++;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        n_checks++;
        if (got != 3) $display("FAIL b2b_count: got %0d want 3", got);
        else n_pass++;
        n_checks++;
        if (rises.size() != 3 || rises[1] - rises[0] != 3 || rises[2] - rises[1] != 3)
            $display("FAIL b2b_period: got %0d rises, spacing %0d %0d want 3 rises spacing 3 3",
                     rises.size(), (rises.size() > 1) ? rises[1] - rises[0] : -1,
                     (rises.size() > 2) ? rises[2] - rises[1] : -1);
        else n_pass++;
        @(negedge PCLK);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL b2b_idle: got busy %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        comp_wait = -1;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_addr = 5'h03; cmd_write = 1'b0; rsp_ready = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE} !== 2'b11) $display("FAIL pre_reset_access: got %b want 11", {PSEL, PENABLE});
        else n_pass++;
        #2 PRESET = 1'b1;
        #1;
        n_checks++;
        if ({PSEL, PENABLE, rsp_valid, busy} !== 4'b0000)
            $display("FAIL async_reset_access: got psel %b pen %b rv %b busy %b want 0 0 0 0", PSEL, PENABLE, rsp_valid, busy);
        else n_pass++;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        n_checks++;
        if ({busy, PSEL} !== 2'b00) $display("FAIL post_reset_idle: got busy %b psel %b want 0 0", busy, PSEL);
        else n_pass++;
        mem[5'h11] = 8'h6E;
        run_txn(5'h11, 1'b0, 8'h00, 1, 0);

        // A response waiting in RESP is dropped by reset
        comp_wait = 0;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_addr = 5'h07; cmd_write = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        n_checks++;
        if (rsp_valid !== 1'b1) $display("FAIL pending_rsp: got %b want 1", rsp_valid);
        else n_pass++;
        #2 PRESET = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_rdata, rsp_error, busy} !== '0)
            $display("FAIL async_reset_resp: got rv %b rd %h err %b busy %b want 0 00 0 0", rsp_valid, rsp_rdata, rsp_error, busy);
        else n_pass++;
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_txn(5'($urandom), 1'($urandom), 8'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
    endtask

    initial begin
        PRESET = 1'b1;
        PREADY = 1'b0;
        PRDATA = '0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        test_reset();
        test_read_basic();
        test_write_waits();
        test_timeout();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
